// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port command arbiter and sequencer in front of a 16x8
// synchronous-write, registered-read memory. One command is in flight at a
// time: IDLE accepts, ACCESS drives the memory, CAPTURE (reads only) samples
// mem_dout and returns it as a one-cycle response pulse on the requesting port.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; leave it undefined for fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // port 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    // port 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    // memory side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                grant;       // port id that wins this cycle
    logic                idle_ok;     // arbiter can accept a command
    logic                hs;          // a command is accepted this cycle

    logic                we_q;
    logic                port_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;

    logic                rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp1_rdata_q;

`ifdef MEM_ARB_RR_EN
    logic                prio_q;      // port favoured on a tie

    // Priority pointer: after each accepted command, favour the other port.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (hs) begin
            prio_q <= ~grant;
        end
    end
`endif

    // Grant selection: a lone requester wins; a tie goes to the favoured port.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_RR_EN
            grant = prio_q;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is offered only to the granted, requesting port while idle and
    // out of reset; it is built from valid and state, never from ready.
    assign idle_ok    = (state_q == IDLE) && !rst;
    assign req0_ready = idle_ok && req0_valid && !grant;
    assign req1_ready = idle_ok && req1_valid &&  grant;
    assign hs         = req0_ready || req1_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and memory write strobe.
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) state_d = ACCESS;
            end
            ACCESS: begin
                mem_we  = we_q;
                state_d = we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch; the address and data registers also drive the memory
    // directly, so they hold their last values outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            port_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (hs) begin
            we_q   <= grant ? req1_we    : req0_we;
            port_q <= grant;
            addr_q <= grant ? req1_addr  : req0_addr;
            din_q  <= grant ? req1_wdata : req0_wdata;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;

    // Read response: capture mem_dout for the latched port and pulse its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= (state_q == CAPTURE) && !port_q;
            rsp1_valid_q <= (state_q == CAPTURE) &&  port_q;
            if ((state_q == CAPTURE) && !port_q) rsp0_rdata_q <= mem_dout;
            if ((state_q == CAPTURE) &&  port_q) rsp1_rdata_q <= mem_dout;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic. A
// transaction-level model predicts, at each accepted command, when the
// memory write or read response must appear; a separate monitor compares
// the DUT against those predictions every cycle.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_we;
    logic [3:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [3:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp1_rdata;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write, registered read (old data on a same-cycle hit).
    logic [7:0] mem [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared between driver and monitor ----------------
    bit done    = 1'b0;
    int log_sel = 0;     // which grant log the monitor fills (0 = none)
    int tmo_cnt = 0;     // handshakes that never arrived within budget

    // ---------------- scoreboard / model state (monitor only) ----------
    typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [7:0] data; } rd_t;

    wr_t        wq[$];
    rd_t        rq0[$], rq1[$];
    logic [7:0] ref_mem [16] = '{default: 8'h00};
    logic [7:0] last0, last1;
    logic [3:0] exp_addr;
    logic [7:0] exp_din;
    bit         prio;
    int         next_free;
    bit         model_on = 1'b0;
    int         glog1[$], glog2[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit  exp_we, exp_v0, exp_v1, idle, e0, e1, p, cwe;
        logic [3:0] ca;
        logic [7:0] cd;
        wr_t w;
        rd_t r;
        int  exp_fair [6];
`ifdef MEM_ARB_RR_EN
        exp_fair = '{0, 1, 0, 1, 0, 1};
`else
        exp_fair = '{0, 0, 0, 0, 0, 0};
`endif
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc > 20000) begin
                check("watchdog", 1, 0);
                break;
            end
            e0 = 1'b0;
            e1 = 1'b0;
            if (model_on) begin
                exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
                check("mem_we", mem_we, exp_we);
                if (exp_we) begin
                    w = wq.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_din", mem_din, w.data);
                end
                check("mem_addr", mem_addr, exp_addr);
                check("mem_din", mem_din, exp_din);

                exp_v0 = (rq0.size() > 0) && (rq0[0].cyc == cyc);
                if (exp_v0) begin r = rq0.pop_front(); last0 = r.data; end
                exp_v1 = (rq1.size() > 0) && (rq1[0].cyc == cyc);
                if (exp_v1) begin r = rq1.pop_front(); last1 = r.data; end
                check("rsp0_valid", rsp0_valid, exp_v0);
                check("rsp0_rdata", rsp0_rdata, last0);
                check("rsp1_valid", rsp1_valid, exp_v1);
                check("rsp1_rdata", rsp1_rdata, last1);

                idle = !rst && (cyc >= next_free);
                e0 = idle && req0_valid && (!req1_valid || !prio);
                e1 = idle && req1_valid && (!req0_valid ||  prio);
                check("req0_ready", req0_ready, e0);
                check("req1_ready", req1_ready, e1);
            end

            // grant log from what the DUT actually accepted
            if (req0_valid && req0_ready) begin
                if (log_sel == 1) glog1.push_back(0);
                if (log_sel == 2) glog2.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                if (log_sel == 1) glog1.push_back(1);
                if (log_sel == 2) glog2.push_back(1);
            end

            // advance the model to the next cycle
            if (rst) begin
                model_on  = 1'b1;
                wq.delete();
                rq0.delete();
                rq1.delete();
                last0     = 8'h00;
                last1     = 8'h00;
                exp_addr  = 4'h0;
                exp_din   = 8'h00;
                prio      = 1'b0;
                next_free = cyc + 1;
            end else if (e0 || e1) begin
                p   = e1;
                cwe = p ? req1_we    : req0_we;
                ca  = p ? req1_addr  : req0_addr;
                cd  = p ? req1_wdata : req0_wdata;
                exp_addr = ca;
                exp_din  = cd;
                if (cwe) begin
                    ref_mem[ca] = cd;
                    wq.push_back('{cyc + 1, ca, cd});
                    next_free = cyc + 2;
                end else begin
                    if (p) rq1.push_back('{cyc + 3, ref_mem[ca]});
                    else   rq0.push_back('{cyc + 3, ref_mem[ca]});
                    next_free = cyc + 3;
                end
`ifdef MEM_ARB_RR_EN
                prio = ~p;
`endif
            end
        end

        check("simul_n", glog1.size(), 2);
        if (glog1.size() == 2) begin
            check("simul_first", glog1[0], 0);
            check("simul_second", glog1[1], 1);
        end
        check("fair_n", glog2.size(), 6);
        for (int i = 0; i < glog2.size() && i < 6; i++)
            check($sformatf("fair_%0d", i), glog2[i], exp_fair[i]);
        check("timeouts", tmo_cnt, 0);
        check("wq_left", wq.size(), 0);
        check("rq0_left", rq0.size(), 0);
        check("rq1_left", rq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- driver ----------------
    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [3:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one request until accepted; returns 1 ns into the following cycle.
    task automatic do_req(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        set_port(p, 1'b1, we, a, d);
        forever begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) break;
            n++;
            if (n > 30) begin tmo_cnt++; break; end
        end
        step(1);
        set_port(p, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    // Present both requests in the same cycle; drop each once accepted.
    task automatic run_both(input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                            input logic we1, input logic [3:0] a1, input logic [7:0] d1);
        int n = 0;
        bit s0 = 1'b0, s1 = 1'b0;
        set_port(0, 1'b1, we0, a0, d0);
        set_port(1, 1'b1, we1, a1, d1);
        while (!(s0 && s1)) begin
            @(negedge clk);
            if (req0_ready) s0 = 1'b1;
            if (req1_ready) s1 = 1'b1;
            step(1);
            if (s0) req0_valid = 1'b0;
            if (s1) req1_valid = 1'b0;
            n++;
            if (n > 30) begin tmo_cnt++; break; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin : driver
        int n;
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step(3);
        rst = 1'b0;
        step(1);

        // single port write then read
        do_req(0, 1'b1, 4'd1, 8'hA5);
        do_req(0, 1'b0, 4'd1, 8'h00);
        step(4);

        // simultaneous writes straight out of reset, then read both back
        rst_pulse();
        log_sel = 1;
        run_both(1'b1, 4'd2, 8'h5A, 1'b1, 4'd3, 8'h3C);
        log_sel = 0;
        do_req(0, 1'b0, 4'd2, 8'h00);
        do_req(1, 1'b0, 4'd3, 8'h00);
        step(4);

        // fairness: both ports hold reads for six grants
        rst_pulse();
        log_sel = 2;
        set_port(0, 1'b1, 1'b0, 4'd2, 8'h00);
        set_port(1, 1'b1, 1'b0, 4'd3, 8'h00);
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            n += int'(req0_ready) + int'(req1_ready);
            step(1);
        end
        if (n < 6) tmo_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        log_sel = 0;
        step(4);

        // read-after-write across ports
        do_req(1, 1'b1, 4'd15, 8'hFF);
        do_req(0, 1'b0, 4'd15, 8'h00);
        step(4);

        // reset during CAPTURE, with a competing request held under reset
        do_req(0, 1'b0, 4'd1, 8'h00);
        step(0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_port(1, 1'b1, 1'b0, 4'd3, 8'h00);
        step(1);
        rst = 1'b0;
        set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step(3);

        // withdrawn request from port 1 while port 0 is being served
        do_req(0, 1'b0, 4'd2, 8'h00);
        set_port(1, 1'b1, 1'b1, 4'd7, 8'h77);
        step(1);
        set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step(4);

        // random traffic with occasional resets
        repeat (400) begin
            rst = ($urandom_range(0, 63) == 0);
            set_port(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 8'($urandom));
            set_port(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 8'($urandom));
            step(1);
        end
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_port(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step(6);
        done = 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of `simple_memory` (16 x 8, synchronous write, registered read). Two clients issue read or write commands over a valid/ready handshake. The block grants one command at a time, drives the memory's `we`/`addr`/`din`, captures `dout` for reads, and returns the data to the requesting port as a one-cycle response pulse.

## Interface
- `ADDR_W`, 4, memory address width
- `DATA_W`, 8, memory data width

Ports:
- `clk` input 1: single clock; all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `req0_valid` input 1: port 0 command valid
- `req0_ready` output 1: port 0 command accepted this cycle when `req0_valid` is also high
- `req0_we` input 1: port 0 command type; 1 = write, 0 = read
- `req0_addr` input ADDR_W: port 0 address
- `req0_wdata` input DATA_W: port 0 write data
- `rsp0_valid` output 1: port 0 read data valid, one-cycle pulse
- `rsp0_rdata` output DATA_W: port 0 read data
- `req1_*`, `rsp1_*`: identical set for port 1
- `mem_we` output 1: to `simple_memory.we`
- `mem_addr` output ADDR_W: to `simple_memory.addr`
- `mem_din` output DATA_W: to `simple_memory.din`
- `mem_dout` input DATA_W: from `simple_memory.dout`

## Operation
- FSM states:
  - IDLE: accepts a command.
  - ACCESS: drives memory.
  - CAPTURE: read only; samples `mem_dout`.
- FSM transitions:
  - IDLE -> ACCESS on handshake.
  - ACCESS -> IDLE for a write.
  - ACCESS -> CAPTURE for a read.
  - CAPTURE -> IDLE always.
- Ready generation:
  - `reqN_ready` is combinational and is high only when state = IDLE, `rst` = 0, and port N holds the grant.
  - Ready to the non-granted port is 0.
  - Ready never depends on `reqN_ready` itself.
- Grant:
  - Only one port valid: that port is granted.
  - Both ports valid: the priority port is granted.
  - The priority pointer updates only on a handshake and points to the port not just served.
  - Reset value of the pointer: port 0.
- Command latch: on handshake, register `we`, `addr`, `wdata` and the granted port id. Requester inputs are don't-care afterwards.
- ACCESS state:
  - `mem_we` = latched `we`; `mem_addr` and `mem_din` = latched values.
  - `mem_we` is 0 in every other state.
  - `mem_addr` and `mem_din` hold their last values outside ACCESS.
- CAPTURE state:
  - Register `mem_dout` into `rspN_rdata` of the latched port only.
  - Assert that port's `rspN_valid` for exactly one cycle.
- Write responses: writes produce no response.
- Response flow control: no response backpressure; the requester must take `rspN_valid` when it pulses.
- `rspN_rdata` holds its value until the next read response to the same port.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_din`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp0_rdata`=`rsp1_rdata`=0, `req0_ready`=`req1_ready`=0, state=IDLE.
- Reset mid-operation: the command in flight is abandoned.
  - No response is issued.
  - `mem_we` is 0 from the cycle after `rst` is sampled.
  - A write already sampled by memory is not undone.
- Valid dropped without ready: the request is withdrawn and no side effects occur.

## Timing
- Cycle numbering: cycle T is the handshake cycle in IDLE.
- Write:
  - T+1: ACCESS, `mem_we`=1; memory writes at the end of T+1.
  - T+2: IDLE; the next handshake is possible. Throughput is 1 write per 2 cycles.
- Read:
  - T+1: ACCESS, `mem_addr` driven; memory registers `dout` at the end of T+1.
  - T+2: CAPTURE; `mem_dout` is valid.
  - T+3: `rspN_valid`=1 with `rspN_rdata`; state is IDLE, and a new handshake may occur in the same cycle T+3.
  - Read latency from handshake to response: 3 cycles. Throughput: 1 read per 3 cycles.
- A read to the address written by the immediately preceding write returns the new data.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin grant as described under Operation.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; port 0 always wins simultaneous requests.
  - The priority pointer register is removed.
  - All other behaviour is unchanged.

## Test plan
- Single port, write then read:
  - Stimulus: port 0 writes 0xA5 to addr 1, then reads addr 1.
  - Required: `mem_we`=1 for exactly 1 cycle with addr 1 and din 0xA5.
  - Required: `rsp0_valid` pulses exactly 3 cycles after the read handshake with `rsp0_rdata`=0xA5.
  - Required: `rsp1_valid` stays 0 throughout.
- Simultaneous writes:
  - Stimulus: out of reset, port 0 writes 0x5A to addr 2 and port 1 writes 0x3C to addr 3, both valid in the same cycle.
  - Required with `MEM_ARB_RR_EN`: port 0 is granted first, port 1 next.
  - Required: reads of addr 2 and addr 3 return 0x5A and 0x3C respectively.
- Fairness:
  - Stimulus: both ports hold valid reads continuously for 6 grants.
  - Required with `MEM_ARB_RR_EN`: grants alternate 0,1,0,1,0,1.
  - Required without `MEM_ARB_RR_EN`: all 6 grants go to port 0.
- Read-after-write:
  - Stimulus: port 1 writes 0xFF to addr 15 at T; port 0 reads addr 15 at T+2.
  - Required: `rsp0_rdata`=0xFF at T+5.
- Reset mid-read:
  - Stimulus: assert `rst` during CAPTURE.
  - Required: no `rsp*_valid` pulse is issued.
  - Required: all outputs return to their reset values on the next cycle.
  - Required: ready is 0 while `rst` is high.
- Withdrawn request:
  - Stimulus: port 1 asserts valid for one cycle while port 0 holds the grant, then drops it.
  - Required: no memory access for port 1 and no `rsp1_valid`.
